// File: rtl/key_pkg.sv
// ============================================================================
// key_pkg : default key-filter timing constants and an ms-to-cycles helper
// Rev 1.0
// ============================================================================
`default_nettype none

package key_pkg;

  localparam int unsigned CLK_HZ  = 50_000_000;
  localparam int unsigned DEB_MS  = 5;
  localparam int unsigned LONG_MS = 1000;
  localparam int unsigned REP_MS  = 200;

  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_filter_chan.sv
// ============================================================================
// key_filter_chan : one active-low key: sync, debounce, press/release/long
// Optional feature macro: KEY_FILTER_LONGPRESS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module key_filter_chan
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = ms_to_cycles(DEB_MS),
  parameter int unsigned LONG_CYCLES = ms_to_cycles(LONG_MS),
  parameter int unsigned REP_CYCLES  = ms_to_cycles(REP_MS)
) (
  input  logic sclk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  // The pin is inverted ahead of the first flop so a cleared synchroniser
  // reads as "not pressed"; a key held through reset is then a fresh press.
  logic [1:0]       sync_q, sync_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             s;

  assign s = sync_q[1];

  always_comb begin
    sync_d    = {sync_q[0], ~key_n};
    deb_cnt_d = deb_cnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == state_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      state_d   = s;
      deb_cnt_d = '0;
      press_d   = s;
      release_d = ~s;
    end else begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_FILTER_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam int unsigned REP_W  = $clog2(REP_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ARM  = HOLD_W'(LONG_CYCLES - 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              rep_act_q, rep_act_d;
  logic              long_q, long_d;

  // Hold count parks at LONG_CYCLES-1 once the first pulse fires; the repeat
  // counter then paces the following pulses.  An edge that accepts a
  // release never emits key_long.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    rep_act_d  = rep_act_q;
    long_d     = 1'b0;
    if (press_d || release_d) begin
      hold_cnt_d = '0;
      rep_cnt_d  = '0;
      rep_act_d  = 1'b0;
    end else if (state_q) begin
      if (!rep_act_q) begin
        if (hold_cnt_q == HOLD_ARM) begin
          hold_cnt_d = HOLD_LAST;
          rep_cnt_d  = '0;
          rep_act_d  = 1'b1;
          long_d     = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end else if (rep_cnt_q == REP_LAST) begin
        rep_cnt_d = '0;
        long_d    = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      rep_act_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_act_q  <= rep_act_d;
      long_q     <= long_d;
    end
  end

  assign key_long = long_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{LONG_CYCLES, REP_CYCLES};
  assign key_long   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/key_filter_array.sv
// ============================================================================
// key_filter_array : N_KEYS independent key filters (press/release/long)
// Optional feature macro: KEY_FILTER_LONGPRESS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module key_filter_array
  import key_pkg::*;
#(
  parameter int unsigned N_KEYS      = 4,
  parameter int unsigned DEB_CYCLES  = ms_to_cycles(DEB_MS),
  parameter int unsigned LONG_CYCLES = ms_to_cycles(LONG_MS),
  parameter int unsigned REP_CYCLES  = ms_to_cycles(REP_MS)
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_filter_chan #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES),
      .REP_CYCLES  (REP_CYCLES)
    ) u_chan (
      .sclk        (sclk),
      .rst_n       (rst_n),
      .key_n       (key_n[gi]),
      .key_state   (key_state[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi]),
      .key_long    (key_long[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_filter_array.sv
// ============================================================================
// tb_key_filter_array : directed + random checks against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_filter_array;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
`ifdef KEY_FILTER_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic         sclk  = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: pin -> 2-edge delay -> accept after DEB differing samples
  bit           m_dly0 [N];
  bit           m_dly1 [N];
  bit           samp   [N][$];
  bit           m_state[N];
  int           m_tpress[N];
  logic [N-1:0] e_state, e_press, e_rel, e_long;

  int press_cnt[N], rel_cnt[N], long_cnt[N];
  int last_press[N], last_rel[N], last_long[N];
  bit all_press_seen;

  key_filter_array #(
    .N_KEYS      (N),
    .DEB_CYCLES  (DEB),
    .LONG_CYCLES (LONG),
    .REP_CYCLES  (REP)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_state   (key_state),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  always #5 sclk = ~sclk;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_dly0[c]  = 1'b0;
      m_dly1[c]  = 1'b0;
      samp[c].delete();
      m_state[c] = 1'b0;
    end
    e_state = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit s;
      bit all_diff;
      int d;
      s          = m_dly1[c];
      m_dly1[c]  = m_dly0[c];
      m_dly0[c]  = ~key_n[c];
      e_press[c] = 1'b0;
      e_rel[c]   = 1'b0;
      e_long[c]  = 1'b0;
      samp[c].push_back(s);
      if (samp[c].size() > DEB) void'(samp[c].pop_front());
      all_diff = (samp[c].size() == DEB);
      foreach (samp[c][i]) if (samp[c][i] == m_state[c]) all_diff = 1'b0;
      if (all_diff) begin
        m_state[c] = s;
        if (s) begin e_press[c] = 1'b1; m_tpress[c] = cyc; end
        else         e_rel[c]   = 1'b1;
      end else if (m_state[c] && LONG_EN) begin
        d = cyc - m_tpress[c];
        if (d >= LONG - 1 && ((d - (LONG - 1)) % REP) == 0) e_long[c] = 1'b1;
      end
      e_state[c] = m_state[c];
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      last_press[c] = -1; last_rel[c] = -1; last_long[c] = -1;
    end
    all_press_seen = 1'b0;
  endtask

  task automatic tick();
    @(posedge sclk);
    cyc++;
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    chk("key_state",   key_state,   e_state);
    chk("key_press",   key_press,   e_press);
    chk("key_release", key_release, e_rel);
    chk("key_long",    key_long,    e_long);
    for (int c = 0; c < N; c++) begin
      if (key_press[c])   begin press_cnt[c]++; last_press[c] = cyc; end
      if (key_release[c]) begin rel_cnt[c]++;   last_rel[c]   = cyc; end
      if (key_long[c])    begin long_cnt[c]++;  last_long[c]  = cyc; end
    end
    if (key_press == '1) all_press_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int e0;
    model_reset();
    clear_obs();

    // reset state
    ticks(3);
    chk("reset_outputs", key_state | key_press | key_release | key_long, '0);
    rst_n = 1'b1;
    ticks(4);

    // clean press on key 0
    clear_obs();
    key_n[0] = 1'b0; e0 = cyc;
    ticks(10);
    chk_int("press0_latency", last_press[0] - e0, 6);
    chk_int("press0_count",   press_cnt[0], 1);
    chk_int("other_presses",  press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    key_n[0] = 1'b1; e0 = cyc;
    ticks(10);
    chk_int("release0_latency", last_rel[0] - e0, 6);

    // bouncing key 1
    clear_obs();
    for (int b = 0; b < 5; b++) begin
      key_n[1] = 1'b0; ticks(3);
      key_n[1] = 1'b1; ticks(1);
    end
    key_n[1] = 1'b0; e0 = cyc;
    ticks(12);
    chk_int("bounce_press_count",   press_cnt[1], 1);
    chk_int("bounce_press_latency", last_press[1] - e0, 6);
    key_n[1] = 1'b1;
    ticks(10);

    // 60-cycle hold on key 2: long pulses then one release
    clear_obs();
    key_n[2] = 1'b0;
    ticks(60);
    key_n[2] = 1'b1; e0 = cyc;
    ticks(10);
    chk_int("long2_count",      long_cnt[2], LONG_EN ? 6 : 0);
    chk_int("long2_last_hold",  LONG_EN ? last_long[2] - last_press[2] : -1, LONG_EN ? 59 : -1);
    chk_int("release2_count",   rel_cnt[2], 1);
    chk_int("release2_latency", last_rel[2] - e0, 6);

    // release lands exactly on a pending repeat pulse (hold count 67)
    clear_obs();
    key_n[3] = 1'b0;
    ticks(67);
    key_n[3] = 1'b1;
    ticks(10);
    chk_int("long3_suppressed", long_cnt[3], LONG_EN ? 6 : 0);
    chk_int("release3_count",   rel_cnt[3], 1);

    // all keys pressed together
    clear_obs();
    key_n = '0;
    ticks(10);
    chk("all_press_same_cycle", {3'b000, all_press_seen}, 4'b0001);
    key_n = '1;
    ticks(12);

    // reset mid-debounce with key still down
    clear_obs();
    key_n[0] = 1'b0;
    ticks(4);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_outputs", key_state | key_press | key_release | key_long, '0);
    ticks(2);
    rst_n = 1'b1; e0 = cyc;
    ticks(10);
    chk_int("post_reset_press_latency", last_press[0] - e0, 6);
    chk_int("post_reset_press_count",   press_cnt[0], 1);
    key_n = '1;
    ticks(12);

    // random pin activity against the model
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 11) == 0) key_n[c] = ~key_n[c];
      tick();
    end
    key_n = '1;
    ticks(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_filter_array.md
KEY_FILTER_ARRAY -- requirements
Module: key_filter_array

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent active-low key channels, range 1..32.
REQ-002 SHALL have parameter DEB_CYCLES, default 250000: stable-sample count required to accept a level change (5 ms at 50 MHz), minimum 2.
REQ-003 SHALL have parameter LONG_CYCLES, default 50000000: held-press duration before the first long-press pulse (1 s), must exceed DEB_CYCLES.
REQ-004 SHALL have parameter REP_CYCLES, default 10000000: auto-repeat period after the first long-press pulse (200 ms), minimum 2.
REQ-005 SHALL have port sclk, input, 1: clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port key_n, input, N_KEYS: raw asynchronous key pins, 0 = pressed.
REQ-008 SHALL have port key_state, output, N_KEYS: debounced level, 1 = pressed.
REQ-009 SHALL have port key_press, output, N_KEYS: one-cycle pulse on accepted press.
REQ-010 SHALL have port key_release, output, N_KEYS: one-cycle pulse on accepted release.
REQ-011 SHALL have port key_long, output, N_KEYS: one-cycle long-press / auto-repeat pulse.

Function
REQ-012 Each channel SHALL be fully independent; no arbitration or cross-channel effects.
REQ-013 Each key_n bit SHALL pass a 2-flop synchroniser; the synchronised value inverted is the sample s.
REQ-014 Debounce counter SHALL clear on every cycle where s equals key_state and increment on every cycle where s differs.
REQ-015 When the counter equals DEB_CYCLES-1 and s still differs, the next edge SHALL set key_state to s, clear the counter, and assert key_press (s=1) or key_release (s=0) for exactly one cycle.
REQ-016 Total latency from a clean pin edge to key_state change SHALL be 2 + DEB_CYCLES cycles.
REQ-017 Any bounce (s returning to key_state) before the threshold SHALL clear the counter; no pulse is emitted and the count restarts on the next difference.
REQ-018 Hold counter SHALL clear on key_press and count while key_state=1; at LONG_CYCLES-1 it SHALL emit key_long, then emit key_long every REP_CYCLES cycles until release.
REQ-019 Hold counter SHALL clear on key_release; a release at the exact cycle of a pending key_long SHALL suppress that key_long.
REQ-020 key_press, key_release and key_long SHALL be mutually exclusive per channel in any cycle.
REQ-021 Counter widths SHALL be $clog2 of their maximum values; counters SHALL never wrap.

Reset
REQ-022 Reset assertion SHALL immediately clear synchronisers, all counters, key_state and all pulse outputs to 0.
REQ-023 A key held through reset release SHALL produce key_press after 2 + DEB_CYCLES cycles, as a fresh press.
REQ-024 Reset mid-debounce or mid-hold SHALL discard the partial count; no pulse SHALL be emitted on or after deassertion from that history.

Configuration
REQ-025 Macro KEY_FILTER_LONGPRESS_EN defined: hold counter and key_long behaviour per REQ-018/019 compiled in.
REQ-026 Macro KEY_FILTER_LONGPRESS_EN undefined: hold counter SHALL be absent, key_long SHALL be tied to 0, and LONG_CYCLES/REP_CYCLES SHALL be ignored.

Structure
REQ-027 Shared package key_pkg SHALL hold the default timing constants (CLK_HZ, DEB_MS, LONG_MS, REP_MS) and a function converting ms to cycles.
REQ-028 Per-channel logic SHALL be a sub-module key_filter_chan, instantiated N_KEYS times by a generate loop; the top contains no other logic.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, REP_CYCLES=8, N_KEYS=4)
REQ-029 Clean press on key_n[0] held 10 cycles -> key_state[0]=1 and a single key_press[0] pulse 6 cycles after the edge; no pulses on other channels.
REQ-030 key_n[1] bounces low 3 cycles / high 1, repeated 5 times, then steady low -> exactly one key_press[1], 6 cycles after the final falling edge.
REQ-031 key_n[2] held low 60 cycles (LONGPRESS_EN) -> key_long[2] at hold counts 19, 27, 35, 43, 51, 59; single key_release 6 cycles after the rising edge.
REQ-032 All four keys pressed on the same cycle -> four key_press bits asserted in the same cycle.
REQ-033 rst_n pulsed low at debounce count 2 with the key still low -> outputs 0 during reset; key_press 6 cycles after deassertion.
REQ-034 Build without KEY_FILTER_LONGPRESS_EN, 60-cycle hold -> key_long stays 0; press/release timing identical to REQ-029.
